// File: rtl/arm_alu_pipe.sv
// arm_alu_pipe: registered ARM data-processing ALU with an NZCV flag register.
// One op per cycle behind a valid/ready skid-free output register. Carry-in for
// ADC/SBC/RSC comes from the architectural C flag, which updates on the accept
// edge so that back-to-back carry chains see the new value without a bubble.
module arm_alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [3:0]       opcode,
  input  logic             set_flags,
  input  logic             shifter_c,
  input  logic             flag_we,
  input  logic [3:0]       flag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             write_y,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } op_e;

  op_e              op;
  logic             accept;
  logic             is_arith;
  logic             is_compare;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] result;
  logic             res_n;
  logic             res_z;
  logic             res_c;
  logic             res_v;

  assign op       = op_e'(opcode);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Adder operand selection: subtracts are x + ~y + cin, reverse forms swap a/b.
  always_comb begin
    add_x    = in_1;
    add_y    = in_2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    unique case (op)
      OP_SUB, OP_CMP: begin add_x = in_1; add_y = ~in_2; add_cin = 1'b1; end
      OP_RSB:         begin add_x = in_2; add_y = ~in_1; add_cin = 1'b1; end
      OP_ADD, OP_CMN: begin add_x = in_1; add_y = in_2;  add_cin = 1'b0; end
      OP_ADC:         begin add_x = in_1; add_y = in_2;  add_cin = C;    end
      OP_SBC:         begin add_x = in_1; add_y = ~in_2; add_cin = C;    end
      OP_RSC:         begin add_x = in_2; add_y = ~in_1; add_cin = C;    end
      default:        is_arith = 1'b0;
    endcase
  end

  // Shared (WIDTH+1)-bit adder; the top bit is the ARM carry (NOT borrow).
  always_comb begin
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  end

  // Logical-op result path.
  always_comb begin
    logic_res = '0;
    unique case (op)
      OP_AND, OP_TST: logic_res = in_1 & in_2;
      OP_EOR, OP_TEQ: logic_res = in_1 ^ in_2;
      OP_ORR:         logic_res = in_1 | in_2;
      OP_MOV:         logic_res = in_2;
      OP_BIC:         logic_res = in_1 & ~in_2;
      OP_MVN:         logic_res = ~in_2;
      default:        logic_res = '0;
    endcase
  end

  // Final result and candidate flags for this op.
  always_comb begin
    is_compare = (opcode[3:2] == 2'b10);
    result     = is_arith ? add_sum[WIDTH-1:0] : logic_res;
    res_n      = result[MSB];
    res_z      = (result == '0);
    if (is_arith) begin
      res_c = add_sum[WIDTH];
      res_v = (add_x[MSB] == add_y[MSB]) && (add_sum[MSB] != add_x[MSB]);
    end else begin
      res_c = shifter_c;
      res_v = V;
    end
  end

  // Output register with valid/ready handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      Y         <= '0;
      write_y   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      Y         <= result;
      write_y   <= !is_compare;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // NZCV register: an accepted S-op takes priority over a direct flag load.
  always_ff @(posedge clk) begin
    if (reset) begin
      {N, Z, C, V} <= '0;
    end else if (accept && set_flags) begin
      {N, Z, C, V} <= {res_n, res_z, res_c, res_v};
    end else if (flag_we) begin
      {N, Z, C, V} <= flag_in;
    end
  end

endmodule
